// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - states, opcodes and mux-select constants for the RV64I multicycle control unit
package controle_pkg;

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_EXEC_R    = 5'd3,
    S_EXEC_I    = 5'd4,
    S_ALU_WB    = 5'd5,
    S_MEM_ADDR  = 5'd6,
    S_MEM_READ  = 5'd7,
    S_LOAD_WB   = 5'd8,
    S_MEM_WRITE = 5'd9,
    S_BRANCH    = 5'd10,
    S_LUI       = 5'd11,
    S_JAL       = 5'd12,
    S_JALR      = 5'd13,
    S_HALT      = 5'd14,
    S_EXC       = 5'd15
  } state_t;

  localparam logic [4:0] RESET_STATE    = 5'd0;
  localparam logic [1:0] EXC_VECTOR_SEL = 2'd3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] PC_ALU       = 2'd0;
  localparam logic [1:0] PC_ALUOUT    = 2'd1;
  localparam logic [1:0] PC_ALU_ALIGN = 2'd2;
  localparam logic [1:0] PC_EXC       = EXC_VECTOR_SEL;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_REG    = 2'd1;
  localparam logic [1:0] SRC_A_ZERO   = 2'd2;
  localparam logic [1:0] SRC_A_PC_OLD = 2'd3;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  // Dispatch from DECODE; unsupported encodings fall to the caller's invalid target.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3,
                                         input state_t invalid);
    state_t nxt;
    nxt = invalid;
    case (op)
      OP_R:      nxt = S_EXEC_R;
      OP_I:      nxt = S_EXEC_I;
      OP_LOAD:   if (f3 == 3'b011) nxt = S_MEM_ADDR;
      OP_STORE:  if (f3 == 3'b011) nxt = S_MEM_ADDR;
      OP_BRANCH: if (f3 == 3'b000 || f3 == 3'b001) nxt = S_BRANCH;
      OP_LUI:    nxt = S_LUI;
      OP_JAL:    nxt = S_JAL;
      OP_JALR:   nxt = S_JALR;
      default:   nxt = invalid;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/decodificador_alu.sv
// rtl/decodificador_alu.sv - funct3/funct7 to alu_op mapping for R- and I-type ALU instructions
module decodificador_alu
  import controle_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       is_rtype,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      // I-type never subtracts: its funct7 field is immediate bits.
      3'b000:  alu_op = (is_rtype && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle RV64I control FSM; CTRL_EXCEPTION_EN routes invalid instructions to EXC instead of HALT
module unidade_controle
  import controle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_old_write,
  output logic       ir_write,
  output logic       mem_data_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [2:0] imm_sel,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_src,
  output logic       epc_write,
  output logic [4:0] stateOut
);

`ifdef CTRL_EXCEPTION_EN
  localparam state_t INVALID_TARGET = S_EXC;
`else
  localparam state_t INVALID_TARGET = S_HALT;
`endif

  state_t     state, next_state;
  logic [2:0] alu_dec;

  decodificador_alu u_dec (
    .funct3   (funct3),
    .funct7   (funct7),
    .is_rtype (state == S_EXEC_R),
    .alu_op   (alu_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= state_t'(RESET_STATE);
    else       state <= next_state;
  end

  assign stateOut = state;

  always_comb begin
    next_state     = state;
    pc_write       = 1'b0;
    pc_old_write   = 1'b0;
    ir_write       = 1'b0;
    mem_data_write = 1'b0;
    mdr_write      = 1'b0;
    reg_write      = 1'b0;
    ab_write       = 1'b0;
    alu_out_write  = 1'b0;
    alu_src_a      = SRC_A_PC;
    alu_src_b      = SRC_B_REG;
    alu_op         = ALU_ADD;
    imm_sel        = IMM_I;
    wb_sel         = WB_ALUOUT;
    pc_src         = PC_ALU;
    epc_write      = 1'b0;

    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        ir_write     = 1'b1;
        pc_old_write = 1'b1;
        alu_src_b    = SRC_B_FOUR;
        pc_write     = 1'b1;
        next_state   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        ab_write      = 1'b1;
        alu_src_a     = SRC_A_PC_OLD;
        alu_src_b     = SRC_B_IMM;
        imm_sel       = IMM_B;
        alu_out_write = 1'b1;
        next_state    = decode_next(opcode, funct3, INVALID_TARGET);
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = (state == S_EXEC_R) ? SRC_B_REG : SRC_B_IMM;
        alu_op        = alu_dec;
        alu_out_write = 1'b1;
        next_state    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = SRC_B_IMM;
        imm_sel       = (opcode == OP_STORE) ? IMM_S : IMM_I;
        alu_out_write = 1'b1;
        next_state    = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mdr_write  = 1'b1;
        next_state = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        wb_sel     = WB_MDR;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_data_write = 1'b1;
        next_state     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_REG;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_write   = (funct3 == 3'b000) ? zero : !zero;
        next_state = S_FETCH;
      end
      S_LUI: begin
        alu_src_a  = SRC_A_ZERO;
        alu_src_b  = SRC_B_IMM;
        imm_sel    = IMM_U;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_PC_OLD;
        alu_src_b  = SRC_B_IMM;
        imm_sel    = IMM_J;
        reg_write  = 1'b1;
        wb_sel     = WB_PC;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        reg_write  = 1'b1;
        wb_sel     = WB_PC;
        pc_write   = 1'b1;
        pc_src     = PC_ALU_ALIGN;
        next_state = S_FETCH;
      end
      S_HALT: next_state = S_HALT;
`ifdef CTRL_EXCEPTION_EN
      S_EXC: begin
        epc_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = PC_EXC;
        next_state = S_FETCH;
      end
`endif
      default: next_state = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - scoreboard bench for unidade_controle with instruction-level reference model
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       zero = 1'b0;
  logic       pc_write, pc_old_write, ir_write, mem_data_write, mdr_write;
  logic       reg_write, ab_write, alu_out_write, epc_write;
  logic [1:0] alu_src_a, alu_src_b, wb_sel, pc_src;
  logic [2:0] alu_op, imm_sel;
  logic [4:0] stateOut;

  unidade_controle dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .pc_write(pc_write), .pc_old_write(pc_old_write), .ir_write(ir_write),
    .mem_data_write(mem_data_write), .mdr_write(mdr_write), .reg_write(reg_write),
    .ab_write(ab_write), .alu_out_write(alu_out_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .wb_sel(wb_sel),
    .pc_src(pc_src), .epc_write(epc_write), .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] W_PC = 9'h100, W_PCOLD = 9'h080, W_IR = 9'h040, W_MEM = 9'h020;
  localparam logic [8:0] W_MDR = 9'h010, W_REG = 9'h008, W_AB = 9'h004, W_ALUOUT = 9'h002;
  localparam logic [8:0] W_EPC = 9'h001;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_BR = 4, K_LUI = 5, K_JAL = 6, K_JALR = 7;

  typedef struct {
    logic [4:0] st;
    logic [8:0] wen;
    bit         chk_alu;
    logic [2:0] alu;
    logic [1:0] wbs;
    logic [1:0] pcs;
    bit         zero_all;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_cyc = 0;

  // Monitor: one expectation per clock cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [8:0] act_wen;
      me = sb.pop_front();
      n_cyc++;
      act_wen = {pc_write, pc_old_write, ir_write, mem_data_write, mdr_write,
                 reg_write, ab_write, alu_out_write, epc_write};
      n_cmp++;
      if (stateOut !== me.st) begin
        n_fail++;
        $display("FAIL state cyc%0d: got %0d expected %0d", n_cyc, stateOut, me.st);
      end
      n_cmp++;
      if (act_wen !== me.wen) begin
        n_fail++;
        $display("FAIL enables cyc%0d st%0d: got %b expected %b", n_cyc, me.st, act_wen, me.wen);
      end
      if (me.chk_alu) begin
        n_cmp++;
        if (alu_op !== me.alu) begin
          n_fail++;
          $display("FAIL alu_op cyc%0d st%0d: got %0d expected %0d", n_cyc, me.st, alu_op, me.alu);
        end
      end
      if ((me.wen & W_REG) != 9'd0) begin
        n_cmp++;
        if (wb_sel !== me.wbs) begin
          n_fail++;
          $display("FAIL wb_sel cyc%0d st%0d: got %0d expected %0d", n_cyc, me.st, wb_sel, me.wbs);
        end
      end
      if ((me.wen & W_PC) != 9'd0) begin
        n_cmp++;
        if (pc_src !== me.pcs) begin
          n_fail++;
          $display("FAIL pc_src cyc%0d st%0d: got %0d expected %0d", n_cyc, me.st, pc_src, me.pcs);
        end
      end
      if (me.zero_all) begin
        n_cmp++;
        if ({act_wen, alu_src_a, alu_src_b, alu_op, imm_sel, wb_sel, pc_src, stateOut} !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs cyc%0d: got nonzero outputs (alu_op %0d wb_sel %0d pc_src %0d)",
                   n_cyc, alu_op, wb_sel, pc_src);
        end
      end
    end
  end

  task automatic push(input logic [4:0] st, input logic [8:0] wen, input bit chk_alu,
                      input logic [2:0] alu, input logic [1:0] wbs, input logic [1:0] pcs);
    exp_t e;
    e.st = st; e.wen = wen; e.chk_alu = chk_alu; e.alu = alu;
    e.wbs = wbs; e.pcs = pcs; e.zero_all = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_reset();
    exp_t e;
    e.st = 5'd0; e.wen = 9'd0; e.chk_alu = 1'b1; e.alu = 3'd0;
    e.wbs = 2'd0; e.pcs = 2'd0; e.zero_all = 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference ALU selection from the instruction's funct fields.
  function automatic logic [2:0] ref_alu(input bit rtype, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (rtype && f7 == 7'h20) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  task automatic do_reset(input int hold);
    reset = 1'b1;
    repeat (hold) begin
      push_reset();
      tick(1);
    end
    reset = 1'b0;
    push_reset();
    tick(1);
  endtask

  task automatic push_front_end();
    push(5'd1, W_PC | W_PCOLD | W_IR, 1'b1, 3'd0, 2'd0, 2'd0);
    push(5'd2, W_AB | W_ALUOUT, 1'b1, 3'd0, 2'd0, 2'd0);
  endtask

  task automatic run_instr(input int k, input logic [2:0] f3, input logic [6:0] f7, input logic z);
    int  n;
    logic taken;
    case (k)
      K_R:     opcode = 7'b0110011;
      K_I:     opcode = 7'b0010011;
      K_LD:    opcode = 7'b0000011;
      K_SD:    opcode = 7'b0100011;
      K_BR:    opcode = 7'b1100011;
      K_LUI:   opcode = 7'b0110111;
      K_JAL:   opcode = 7'b1101111;
      default: opcode = 7'b1100111;
    endcase
    funct3 = f3; funct7 = f7; zero = z;
    push_front_end();
    n = 2;
    case (k)
      K_R, K_I: begin
        push((k == K_R) ? 5'd3 : 5'd4, W_ALUOUT, 1'b1, ref_alu(k == K_R, f3, f7), 2'd0, 2'd0);
        push(5'd5, W_REG, 1'b0, 3'd0, 2'd0, 2'd0);
        n += 2;
      end
      K_LD: begin
        push(5'd6, W_ALUOUT, 1'b1, 3'd0, 2'd0, 2'd0);
        push(5'd7, W_MDR, 1'b0, 3'd0, 2'd0, 2'd0);
        push(5'd8, W_REG, 1'b0, 3'd0, 2'd1, 2'd0);
        n += 3;
      end
      K_SD: begin
        push(5'd6, W_ALUOUT, 1'b1, 3'd0, 2'd0, 2'd0);
        push(5'd9, W_MEM, 1'b0, 3'd0, 2'd0, 2'd0);
        n += 2;
      end
      K_BR: begin
        taken = (f3 == 3'b000) ? z : !z;
        push(5'd10, taken ? W_PC : 9'd0, 1'b1, 3'd1, 2'd0, 2'd1);
        n += 1;
      end
      K_LUI: begin
        push(5'd11, W_REG, 1'b0, 3'd0, 2'd0, 2'd0);
        n += 1;
      end
      K_JAL: begin
        push(5'd12, W_REG | W_PC, 1'b0, 3'd0, 2'd2, 2'd0);
        n += 1;
      end
      default: begin
        push(5'd13, W_REG | W_PC, 1'b0, 3'd0, 2'd2, 2'd2);
        n += 1;
      end
    endcase
    tick(n);
  endtask

  task automatic run_invalid(input logic [6:0] op, input logic [2:0] f3, input int hold);
    opcode = op; funct3 = f3; funct7 = 7'd0; zero = 1'b0;
    push_front_end();
`ifdef CTRL_EXCEPTION_EN
    push(5'd15, W_EPC | W_PC, 1'b0, 3'd0, 2'd0, 2'd3);
    tick(3);
`else
    repeat (hold) push(5'd14, 9'd0, 1'b1, 3'd0, 2'd0, 2'd0);
    tick(2 + hold);
`endif
  endtask

  task automatic run_random(input int count);
    logic [2:0] alu_f3 [5];
    alu_f3[0] = 3'b000; alu_f3[1] = 3'b111; alu_f3[2] = 3'b110;
    alu_f3[3] = 3'b100; alu_f3[4] = 3'b010;
    for (int i = 0; i < count; i++) begin
      int k;
      logic [2:0] f3;
      logic [6:0] f7;
      k  = $urandom_range(0, 7);
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      case (k)
        K_R: begin
          f3 = alu_f3[$urandom_range(0, 4)];
          f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        K_I:        f3 = alu_f3[$urandom_range(0, 4)];
        K_LD, K_SD: f3 = 3'b011;
        K_BR:       f3 = 3'($urandom_range(0, 1));
        default:    ;
      endcase
      run_instr(k, f3, f7, 1'($urandom));
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(K_R, 3'b000, 7'h00, 1'b0);
    run_instr(K_R, 3'b000, 7'h20, 1'b0);
    run_instr(K_I, 3'b000, 7'h7f, 1'b0);
    run_instr(K_I, 3'b000, 7'h20, 1'b1);
    run_instr(K_LD, 3'b011, 7'h00, 1'b0);
    run_instr(K_SD, 3'b011, 7'h00, 1'b0);
    run_instr(K_BR, 3'b000, 7'h00, 1'b1);
    run_instr(K_BR, 3'b000, 7'h00, 1'b0);
    run_instr(K_BR, 3'b001, 7'h00, 1'b1);
    run_instr(K_BR, 3'b001, 7'h00, 1'b0);
    run_instr(K_LUI, 3'b000, 7'h00, 1'b0);
    run_instr(K_JAL, 3'b000, 7'h00, 1'b0);
    run_instr(K_JALR, 3'b000, 7'h00, 1'b0);

    run_random(60);

    // Abort a JAL in its write cycle: reset must clear enables within that cycle.
    opcode = 7'b1101111; funct3 = 3'd0; funct7 = 7'd0;
    push_front_end();
    tick(2);
    do_reset(2);

    run_invalid(7'b1111111, 3'b000, 20);
    do_reset(2);
    run_random(15);
    run_invalid(7'b0000011, 3'b010, 5);
    do_reset(1);
    run_random(10);

    tick(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
